comparador_serie_d_i: RTL and testbench

COMPARADOR_SERIE_D_I -- requirements
Module: comparador_serie_d_i

---
 rtl/comparador_serie_d_i.sv | 99 +++++++++
 tb/tb_comparador_serie_d_i.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/comparador_serie_d_i.sv
// rtl/comparador_serie_d_i.sv - bit-serial LSB-first comparator, WIDTH+1 cycle latency
// Define SIGNED_CMP_EN for two's-complement operands (MSB step feeds the swapped pair).
module comparador_serie_d_i #(
  parameter int   WIDTH  = 8,
  parameter logic X_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [WIDTH-1:0] palabra_a,
  input  logic [WIDTH-1:0] palabra_b,
  output logic             ocupado,
  output logic             listo,
  output logic             menor,
  output logic             igual,
  output logic             mayor
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic             x, eq;
  logic             start, last_bit;
  logic             a_bit, b_bit, x_next, eq_next;

  assign start    = (state == IDLE) && inicio;
  assign last_bit = (cnt == LAST);

`ifdef SIGNED_CMP_EN
  // The sign bit carries inverted weight, so the MSB cell sees (b,a).
  assign a_bit = last_bit ? sh_b[0] : sh_a[0];
  assign b_bit = last_bit ? sh_a[0] : sh_b[0];
`else
  assign a_bit = sh_a[0];
  assign b_bit = sh_b[0];
`endif

  assign x_next  = (~a_bit & b_bit) | (x & b_bit) | (x & ~a_bit);
  assign eq_next = eq & ~(a_bit ^ b_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ocupado    = 1'b0;
    listo      = 1'b0;
    case (state)
      IDLE: if (inicio) state_next = RUN;
      RUN: begin
        ocupado = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        ocupado    = 1'b1;
        listo      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
      x     <= 1'b0;
      eq    <= 1'b0;
      menor <= 1'b0;
      igual <= 1'b0;
      mayor <= 1'b0;
    end else if (start) begin
      sh_a <= palabra_a;
      sh_b <= palabra_b;
      cnt  <= '0;
      x    <= X_INIT;
      eq   <= 1'b1;
    end else if (state == RUN) begin
      sh_a <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b <= {1'b0, sh_b[WIDTH-1:1]};
      cnt  <= cnt + 1'b1;
      x    <= x_next;
      eq   <= eq_next;
      // Results only move on the final bit so they stay stable throughout RUN.
      if (last_bit) begin
        menor <= x_next;
        igual <= eq_next;
        mayor <= ~x_next & ~eq_next;
      end
    end
  end
endmodule

// File: tb/tb_comparador_serie_d_i.sv
// tb/tb_comparador_serie_d_i.sv - randomized bench for comparador_serie_d_i against an arithmetic model
module tb_comparador_serie_d_i;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, inicio;
  logic [W-1:0] pa, pb;
  logic         ocu0, lis0, men0, igu0, may0;
  logic         ocu1, lis1, men1, igu1, may1;
  logic [2:0]   exp0, exp1;
  int           n_vec = 0;
  int           n_err = 0;

  comparador_serie_d_i #(.WIDTH(W), .X_INIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .inicio(inicio), .palabra_a(pa), .palabra_b(pb),
    .ocupado(ocu0), .listo(lis0), .menor(men0), .igual(igu0), .mayor(may0));

  comparador_serie_d_i #(.WIDTH(W), .X_INIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .inicio(inicio), .palabra_a(pa), .palabra_b(pb),
    .ocupado(ocu1), .listo(lis1), .menor(men1), .igual(igu1), .mayor(may1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // {menor, igual, mayor}
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit xi);
    int sa, sb;
`ifdef SIGNED_CMP_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'(a);
    sb = int'(b);
`endif
    return {(xi ? (sa <= sb) : (sa < sb)), (sa == sb), (sa > sb)};
  endfunction

  // Called at a negedge. busy_at: RUN cycle index to inject an ignored inicio (-1 none).
  // done_inicio: raise inicio during the DONE cycle, which must be ignored.
  task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int busy_at, input bit done_inicio);
    logic [2:0] e0, e1;
    e0 = ref_cmp(a, b, 1'b0);
    e1 = ref_cmp(a, b, 1'b1);
    pa = a;
    pb = b;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    for (int j = 0; j < W; j++) begin
      check("run_ocupado", ocu0, 1'b1);
      check("run_listo", {lis0, lis1}, 2'b00);
      check("run_hold0", {men0, igu0, may0}, exp0);
      check("run_hold1", {men1, igu1, may1}, exp1);
      if (j == busy_at) begin
        pa = 8'h00;
        pb = 8'hFF;
        inicio = 1'b1;
      end else begin
        pa = W'($urandom);
        pb = W'($urandom);
        inicio = 1'b0;
      end
      @(negedge clk);
    end
    check("done_listo", {lis0, lis1}, 2'b11);
    check("done_ocupado", {ocu0, ocu1}, 2'b11);
    check("res_x0", {men0, igu0, may0}, e0);
    check("res_x1", {men1, igu1, may1}, e1);
    exp0 = e0;
    exp1 = e1;
    inicio = done_inicio;
    @(negedge clk);
    check("idle_listo", {lis0, lis1}, 2'b00);
    check("idle_ocupado", {ocu0, ocu1}, 2'b00);
    check("idle_hold", {men0, igu0, may0}, exp0);
    inicio = 1'b0;
  endtask

  logic [W-1:0] dir_a [8] = '{8'h05, 8'hA5, 8'h80, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h7F};
  logic [W-1:0] dir_b [8] = '{8'h09, 8'hA5, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h80};

  initial begin
    rst = 1'b1;
    inicio = 1'b0;
    pa = '0;
    pb = '0;
    exp0 = 3'b000;
    exp1 = 3'b000;
    #1;
    check("reset_outs0", {ocu0, lis0, men0, igu0, may0}, 5'b0);
    check("reset_outs1", {ocu1, lis1, men1, igu1, may1}, 5'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_cmp(dir_a[i], dir_b[i], -1, 1'b0);

    do_cmp(8'hF0, 8'h0F, 3, 1'b0);
    check("busy_mayor", may0, ref_cmp(8'hF0, 8'h0F, 1'b0) & 3'b001);

    do_cmp(W'($urandom), W'($urandom), -1, 1'b1);
    do_cmp(8'h33, 8'h34, -1, 1'b0);

    pa = 8'hC3;
    pb = 8'h3C;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_outs0", {ocu0, lis0, men0, igu0, may0}, 5'b0);
    check("midrst_outs1", {ocu1, lis1, men1, igu1, may1}, 5'b0);
    exp0 = 3'b000;
    exp1 = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < W + 3; j++) begin
      check("post_rst_quiet", {lis0, ocu0}, 2'b00);
      @(negedge clk);
    end
    do_cmp(8'h01, 8'h02, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_cmp(W'($urandom), (i % 5 == 0) ? pa : W'($urandom),
             (i % 7 == 0) ? int'($urandom_range(0, W - 1)) : -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
